hazard_ctl: RTL
===============

HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset; ports:
  clk  in  1  rising-edge pipeline clock
  rst_n  in  1  asynchronous active-low reset
  if_id_instr  in  32  instruction in IF/ID; rs=[25:21], rt=[20:16]
  id_ex_memread  in  1  instruction in ID/EX is a load
  id_ex_rt  in  5  load destination register in ID/EX
  id_ex_regwrite  in  1  ID/EX instruction writes the register file
  id_ex_dest  in  5  resolved ID/EX destination (after regdst mux)
  ex_mem_regwrite  in  1  EX/MEM instruction writes the register file
  ex_mem_dest  in  5  EX/MEM destination register
  branch_taken  in  1  branch resolved taken in EX/MEM this cycle
  pc_write  out  1  PC load enable
  if_id_write  out  1  IF/ID load enable
  id_ex_bubble  out  1  zero ID/EX WB/M/EX control fields
  if_id_flush  out  1  replace IF/ID with nop
  ex_mem_flush  out  1  zero EX/MEM control fields
  state  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH
  stall_cnt  out  16  saturating count of stall cycles
  flush_cnt  out  16  saturating count of taken-branch flushes

Function
REQ-002 Hazard comparisons SHALL ignore register 0; hit = nonzero dest equal to rs or rt.
REQ-003 Load-use hit: id_ex_memread=1 and id_ex_rt hits; requires 1 stall cycle.
REQ-004 Needed stall cycles N for the current cycle SHALL be the maximum over all active hazard rules.
REQ-005 pc_write, if_id_write, id_ex_bubble, if_id_flush and ex_mem_flush SHALL be combinational (Mealy) from state, counter and inputs.
REQ-006 In RUN with branch_taken=0 and N=0: pc_write=1, if_id_write=1, all bubble/flush outputs 0; state stays RUN.
REQ-007 In RUN with branch_taken=0 and N>=1: pc_write=0, if_id_write=0, id_ex_bubble=1 this cycle.
REQ-008 From REQ-007, the FSM SHALL stay RUN if N=1, else go to STALL with the remaining-cycle counter loaded with N-1.
REQ-009 In STALL: outputs as REQ-007; the counter SHALL decrement each cycle; return to RUN in the cycle after the counter reaches 1.
REQ-010 While in STALL, new hazard detection SHALL be suppressed.
REQ-011 branch_taken=1 in any state SHALL win over every hazard: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1.
REQ-012 After REQ-011 the next state SHALL be FLUSH, and any STALL counter SHALL be cleared.
REQ-013 FLUSH SHALL last exactly one cycle: pc_write=1, if_id_write=1, all bubble/flush outputs 0, hazard detection suppressed.
REQ-014 FLUSH SHALL go to RUN, or re-enter FLUSH via REQ-011 if branch_taken=1.
REQ-015 stall_cnt SHALL increment on every cycle with id_ex_bubble=1 and branch_taken=0, saturating at 16'hFFFF.
REQ-016 flush_cnt SHALL increment on every branch_taken=1 cycle, saturating at 16'hFFFF.
REQ-017 State encoding 3 SHALL be unreachable; if entered, the next state SHALL be RUN.

Reset
REQ-018 rst_n=0 SHALL immediately force state=RUN, the counter to 0, and stall_cnt=flush_cnt=0, independent of clk.
REQ-019 Under reset, outputs SHALL read pc_write=1, if_id_write=1 and all bubble/flush outputs 0; a stall cut off by reset SHALL NOT resume.

Configuration
REQ-020 Macro HAZARD_FORWARD_EN defined: forwarding exists; only REQ-003 contributes to N.
REQ-021 HAZARD_FORWARD_EN undefined: add RAW rules to REQ-004.
  - id_ex_regwrite=1 and id_ex_dest hits: N>=2.
  - ex_mem_regwrite=1 and ex_mem_dest hits: N>=1.

Verification
REQ-022 Load-use: id_ex_memread=1, id_ex_rt=8, rs=8.
  - One cycle pc_write=0, id_ex_bubble=1; then RUN with no stall.
  - stall_cnt=1.
REQ-023 Register 0: id_ex_memread=1, id_ex_rt=0, rs=0 -> no stall.
REQ-024 Forwarding off: id_ex_regwrite=1, id_ex_dest=9, rt=9.
  - Two stall cycles, state RUN->STALL->RUN, stall_cnt=2.
REQ-024a Forwarding on, same stimulus: no stall.
REQ-025 Branch in stall: branch_taken=1 during STALL.
  - All flush outputs 1 that cycle, then FLUSH, then RUN.
  - flush_cnt=1, no remaining stall.
REQ-026 Async reset: rst_n pulsed low mid-STALL between clock edges.
  - state=0, counters 0 and pc_write=1 before the next edge.

Source files
------------

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: load-use/RAW stall FSM with taken-branch flush and event counters.
// Optional: HAZARD_FORWARD_EN (forwarding present; only load-use hazards stall).
module hazard_ctl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_id_instr,
    input  logic        id_ex_memread,
    input  logic [4:0]  id_ex_rt,
    input  logic        id_ex_regwrite,
    input  logic [4:0]  id_ex_dest,
    input  logic        ex_mem_regwrite,
    input  logic [4:0]  ex_mem_dest,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        ex_mem_flush,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_BAD   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [4:0]  rs, rt;
    logic [1:0]  need;

    assign rs = if_id_instr[25:21];
    assign rt = if_id_instr[20:16];

    // Register 0 is hardwired to zero, so it can never carry a dependency.
    function automatic logic hit(input logic [4:0] dest, input logic [4:0] src_s,
                                 input logic [4:0] src_t);
        return (dest != 5'd0) && ((dest == src_s) || (dest == src_t));
    endfunction

    always_comb begin
        need = 2'd0;
`ifndef HAZARD_FORWARD_EN
        if (ex_mem_regwrite && hit(ex_mem_dest, rs, rt)) need = 2'd1;
`endif
        if (id_ex_memread && hit(id_ex_rt, rs, rt)) need = 2'd1;
`ifndef HAZARD_FORWARD_EN
        if (id_ex_regwrite && hit(id_ex_dest, rs, rt)) need = 2'd2;
`endif
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (branch_taken) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = ST_FLUSH;
            cnt_d        = 2'd0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (need != 2'd0) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (need != 2'd1) begin
                            state_d = ST_STALL;
                            cnt_d   = need - 2'd1;
                        end
                    end
                end
                ST_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (cnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                ST_FLUSH: state_d = ST_RUN;
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end

        // Reset overrides the Mealy outputs so stale hazard inputs cannot freeze the front end.
        if (!rst_n) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
            if_id_flush  = 1'b0;
            ex_mem_flush = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (id_ex_bubble && !branch_taken && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (branch_taken && (flush_cnt_q != 16'hFFFF))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= 2'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
